// File: rtl/lc3_useq_stack.sv
// LC-3 microsequencer with registered microstate and BEN, a microcode
// return-address stack (call/return) and a memory-wait timeout that vectors
// to a fault microstate. Sits between the control store and the datapath.
module lc3_useq_stack #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 18,
    parameter int FAULT_ADDR  = 63,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                               i_CLK,
    input  logic                               i_Reset,
    input  logic [ADDR_W-1:0]                  i_j_field,
    input  logic [2:0]                         i_COND_bits,
    input  logic                               i_IRD,
    input  logic                               i_LD_BEN,
    input  logic                               i_Call,
    input  logic                               i_Ret,
    input  logic [ADDR_W-1:0]                  i_CallTarget,
    input  logic                               i_R_Bit,
    input  logic [6:0]                         i_IR_15_9,
    input  logic [2:0]                         i_NZP,
    input  logic                               i_PSR_15,
    input  logic                               i_INT,
    input  logic                               i_ACV,
    output logic [ADDR_W-1:0]                  o_AddressNextState,
    output logic [ADDR_W-1:0]                  o_State,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_StackDepth,
    output logic                               o_StackErr,
    output logic                               o_MemTimeout
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    // The counter only has to reach MEM_TIMEOUT-1 before it is cleared.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] RESET_A  = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] FAULT_A  = ADDR_W'(FAULT_ADDR);
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic              TO_EN    = (MEM_TIMEOUT > 0);

    logic                r_ben;
    logic [SP_W-1:0]     sp;
    logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];
    logic [CNT_W-1:0]    wait_cnt;

    logic [ADDR_W-1:0]   cond_mask;
    logic [ADDR_W-1:0]   base_addr;
    logic                waiting;
    logic                timeout;
    logic                do_push;
    logic                do_pop;
    logic                set_err;
    logic                ben_next;
    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W-1:0]    push_idx;

    assign top_idx  = IDX_W'(sp - 1'b1);
    assign push_idx = IDX_W'(sp);
    assign ben_next = (i_IR_15_9[2] & i_NZP[2]) | (i_IR_15_9[1] & i_NZP[1])
                    | (i_IR_15_9[0] & i_NZP[0]);

    assign waiting = (i_COND_bits == 3'b001) && !i_R_Bit && !i_IRD;
    assign timeout = TO_EN && waiting && (wait_cnt == CNT_LAST);

    assign o_StackDepth = sp;

    // Condition bit selected by COND, ORed into the low bits of j.
    always_comb begin
        cond_mask = '0;
        case (i_COND_bits)
            3'b001:  cond_mask[1] = i_R_Bit;
            3'b010:  cond_mask[2] = r_ben;
            3'b011:  cond_mask[0] = i_IR_15_9[2];
            3'b100:  cond_mask[3] = i_PSR_15;
            3'b101:  cond_mask[4] = i_INT;
            3'b110:  cond_mask[5] = i_ACV;
            default: cond_mask    = '0;
        endcase
        base_addr = i_j_field | cond_mask;
    end

    // Next-address priority chain and the stack actions it implies.
    always_comb begin
        o_AddressNextState = base_addr;
        do_push            = 1'b0;
        do_pop             = 1'b0;
        set_err            = 1'b0;
        if (i_Reset) begin
            o_AddressNextState = RESET_A;
        end else if (timeout) begin
            o_AddressNextState = FAULT_A;
        end else if (i_IRD) begin
            o_AddressNextState = {{(ADDR_W-4){1'b0}}, i_IR_15_9[6:3]};
        end else if (i_Call && i_Ret) begin
            // Tail call: the caller's return address stays where it is.
            o_AddressNextState = i_CallTarget;
        end else if (i_Ret) begin
            if (sp != '0) begin
                o_AddressNextState = stack_mem[top_idx];
                do_pop             = 1'b1;
            end else begin
                o_AddressNextState = FAULT_A;
                set_err            = 1'b1;
            end
        end else if (i_Call) begin
            if (sp < SP_FULL) begin
                o_AddressNextState = i_CallTarget;
                do_push            = 1'b1;
            end else begin
                o_AddressNextState = FAULT_A;
                set_err            = 1'b1;
            end
        end
    end

    // Microstate, BEN, stack pointer, sticky error, wait counter and timeout pulse.
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            o_State      <= RESET_A;
            r_ben        <= 1'b0;
            sp           <= '0;
            o_StackErr   <= 1'b0;
            o_MemTimeout <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            o_State      <= o_AddressNextState;
            o_MemTimeout <= timeout;
            if (i_LD_BEN)
                r_ben <= ben_next;
            if (do_push)
                sp <= sp + 1'b1;
            else if (do_pop)
                sp <= sp - 1'b1;
            if (set_err)
                o_StackErr <= 1'b1;
            if (timeout || !waiting)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Return-address storage; contents are meaningless above sp, so no reset.
    always_ff @(posedge i_CLK) begin
        if (!i_Reset && do_push)
            stack_mem[push_idx] <= base_addr;
    end

endmodule
